mdu_hilo: RTL

- Iterative signed multiply/divide unit with architectural HI/LO registers, sitting in EX directly downstream of the ALU decoder.
- Consumes the decoder's 4-bit ALU control and HI/LO enable; services MULT, DIV, MFHI, MFLO.
- Asserts busy so the hazard unit stalls a following MFHI/MFLO until the operation completes.

---
 rtl/mdu_hilo_if.sv | 24 ++
 rtl/mdu_hilo.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mdu_hilo_if.sv
// Operand/result bundle between the EX stage and the HI/LO multiply/divide unit.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alucontrol;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;

  modport master (
    output start, alucontrol, srca, srcb,
    input  busy, done, hi, lo, result
  );

  modport slave (
    input  start, alucontrol, srca, srcb,
    output busy, done, hi, lo, result
  );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative signed MULT/DIV with architectural HI/LO registers and MFHI/MFLO readout.
// Optional macro MDU_EARLY_TERM_EN: a multiply finishes once the remaining multiplier bits are zero.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  mdu_hilo_if.slave bus
);
  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]      OP_MULT  = 4'b1000;
  localparam logic [3:0]      OP_DIV   = 4'b1001;
  localparam logic [3:0]      OP_MFHI  = 4'b1010;
  localparam logic [3:0]      OP_MFLO  = 4'b1011;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               is_div_q, is_div_d;

  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  // Restoring-division step: the shifted partial remainder carries one extra bit for the borrow.
  assign rem_sh = {rem_q, quot_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, divisor_q};
  assign prod   = neg_q ? (~acc_q + 1'b1) : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.alucontrol == OP_MULT || bus.alucontrol == OP_DIV)) begin
          acc_d     = '0;
          mcand_d   = {{WIDTH{1'b0}}, mag(bus.srca)};
          mplier_d  = mag(bus.srcb);
          rem_d     = '0;
          quot_d    = mag(bus.srca);
          divisor_d = mag(bus.srcb);
          neg_d     = bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1];
          neg_rem_d = bus.srca[WIDTH-1];
          is_div_d  = (bus.alucontrol == OP_DIV);
          cnt_d     = CNT_LAST;
          busy_d    = 1'b1;
          state_d   = (bus.alucontrol == OP_DIV) ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIN;
`ifdef MDU_EARLY_TERM_EN
        if (mplier_d == '0) state_d = S_FIN;
`endif
      end
      S_DIV: begin
        if (!diff[WIDTH]) rem_d = diff[WIDTH-1:0];
        else              rem_d = rem_sh[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIN;
      end
      default: begin
        if (is_div_q) begin
          // A zero divisor leaves an all-ones quotient that must not be sign-corrected.
          lo_d = (neg_q && divisor_q != '0) ? (~quot_q + 1'b1) : quot_q;
          hi_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end else begin
          {hi_d, lo_d} = prod;
        end
        cnt_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the same pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // NOTE: the datapath is fully reloaded at launch, so it carries no reset and stays cheap to fan out.
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    mcand_q   <= mcand_d;
    mplier_q  <= mplier_d;
    rem_q     <= rem_d;
    quot_q    <= quot_d;
    divisor_q <= divisor_d;
    neg_q     <= neg_d;
    neg_rem_q <= neg_rem_d;
    is_div_q  <= is_div_d;
  end

  always_comb begin
    bus.result = '0;
    if (bus.alucontrol == OP_MFHI)      bus.result = hi_q;
    else if (bus.alucontrol == OP_MFLO) bus.result = lo_q;
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
